// File: rtl/buffer_drain_ctrl_if.sv
// Handshake bundle for buffer_drain_ctrl: upstream word port, compaction datapath
// loop (dp_*), and the narrow downstream beat stream.
interface buffer_drain_ctrl_if #(
  parameter int DATA_W    = 8,
  parameter int OUT_LANES = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [15:0]                 in_lane_valids;
  logic [16*DATA_W-1:0]        in_data;

  logic [15:0]                 dp_valids;
  logic [16*DATA_W-1:0]        dp_lanes;
  logic [16*DATA_W-1:0]        dp_slots;

  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_LANES*DATA_W-1:0] out_data;
  logic [OUT_LANES-1:0]        out_keep;
  logic                        out_last;

  // Controller side.
  modport slave (
    input  in_valid, in_lane_valids, in_data, dp_slots, out_ready,
    output in_ready, dp_valids, dp_lanes, out_valid, out_data, out_keep, out_last
  );

  // Upstream/downstream/datapath side.
  modport master (
    output in_valid, in_lane_valids, in_data, dp_slots, out_ready,
    input  in_ready, dp_valids, dp_lanes, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/buffer_drain_ctrl.sv
// Lane-compaction sequencer: registers a 16-lane word, feeds it to the compaction
// datapath and drains the compacted slots OUT_LANES per beat. Optional counters: BUFFER_DRAIN_STATS_EN.
module buffer_drain_ctrl #(
  parameter int DATA_W    = 8,
  parameter int OUT_LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  buffer_drain_ctrl_if.slave  bus_if,
  output logic [15:0]         stat_words_o,
  output logic [15:0]         stat_drops_o
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                      state_q;
  logic [4:0]                  count_q;
  logic [4:0]                  rd_ptr_q;
  logic [15:0]                 dp_valids_q;
  logic [16*DATA_W-1:0]        dp_lanes_q;

  logic                        draining;
  logic                        out_last;
  logic                        beat_done;
  logic                        accept;
  logic [4:0]                  in_count;
  logic [OUT_LANES-1:0]        out_keep;
  logic [OUT_LANES*DATA_W-1:0] out_data;

  function automatic logic [4:0] popcount16(input logic [15:0] mask);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(mask[i]);
    return cnt;
  endfunction

  assign draining  = (state_q == DRAIN);
  // Six-bit compare so rd_ptr + OUT_LANES reaching 16 does not wrap.
  assign out_last  = draining && (({1'b0, rd_ptr_q} + 6'(OUT_LANES)) >= {1'b0, count_q});
  assign beat_done = draining & bus_if.out_ready;
  assign accept    = bus_if.in_valid & bus_if.in_ready;
  assign in_count  = popcount16(bus_if.in_lane_valids);

  assign bus_if.in_ready  = ~draining | (beat_done & out_last);
  assign bus_if.out_valid = draining;
  assign bus_if.out_last  = out_last;
  assign bus_if.out_keep  = out_keep;
  assign bus_if.out_data  = out_data;
  assign bus_if.dp_valids = dp_valids_q;
  assign bus_if.dp_lanes  = dp_lanes_q;

  always_comb begin
    logic [5:0] slot;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    out_keep = '0;
    out_data = '0;
    slot     = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      slot = {1'b0, rd_ptr_q} + 6'(i);
      if (draining && (slot < {1'b0, count_q})) begin
        out_keep[i]                  = 1'b1;
        out_data[i*DATA_W +: DATA_W] = bus_if.dp_slots[slot[3:0]*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later ifs override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      dp_valids_q <= '0;
      dp_lanes_q  <= '0;
    end else begin
      if (beat_done) rd_ptr_q <= rd_ptr_q + 5'(OUT_LANES);
      if (beat_done && out_last) state_q <= IDLE;
      // Acceptance wins over the last-beat return to IDLE on a shared edge.
      if (accept) begin
        if (in_count != 5'd0) begin
          state_q     <= DRAIN;
          count_q     <= in_count;
          rd_ptr_q    <= '0;
          dp_valids_q <= bus_if.in_lane_valids;
          dp_lanes_q  <= bus_if.in_data;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

`ifdef BUFFER_DRAIN_STATS_EN
  logic [15:0] stat_words_q;
  logic [15:0] stat_drops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_drops_q <= '0;
    end else if (accept) begin
      if (stat_words_q != 16'hFFFF) stat_words_q <= stat_words_q + 16'd1;
      if ((in_count == 5'd0) && (stat_drops_q != 16'hFFFF)) stat_drops_q <= stat_drops_q + 16'd1;
    end
  end

  assign stat_words_o = stat_words_q;
  assign stat_drops_o = stat_drops_q;
`else
  assign stat_words_o = '0;
  assign stat_drops_o = '0;
`endif

endmodule
